// File: rtl/layer_mvm_par.sv
// Fully-connected layer engine y = f(W*x + b). P MAC lanes share one x buffer while
// weights and biases stream from external synchronous ROMs, one row group at a time.

module layer_mvm_lane #(
  parameter int T    = 16,
  parameter int AW   = 35,
  parameter int RELU = 1,
  parameter int SAT  = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ld_bias,
  input  logic         ld_prod,
  input  logic         acc_en,
  input  logic [T-1:0] b,
  input  logic [T-1:0] w,
  input  logic [T-1:0] x,
  output logic [T-1:0] fin
);
  logic signed [AW-1:0]  acc, sum, r, maxv, minv;
  logic signed [2*T-1:0] prod, we, xe;

  assign we   = {{T{w[T-1]}}, w};
  assign xe   = {{T{x[T-1]}}, x};
  assign sum  = acc + {{(AW-2*T){prod[2*T-1]}}, prod};
  assign maxv = {{(AW-T+1){1'b0}}, {(T-1){1'b1}}};
  assign minv = {{(AW-T+1){1'b1}}, {(T-1){1'b0}}};

  always_ff @(posedge clk) begin
    if (reset) begin
      acc  <= '0;
      prod <= '0;
    end else begin
      if (ld_bias)     acc <= {{(AW-T){b[T-1]}}, b};
      else if (acc_en) acc <= sum;
      if (ld_prod)     prod <= we * xe;
    end
  end

  // Sampled on the last MAC cycle of a group, so the final product is folded in here.
  always_comb begin
    r = sum;
    if (RELU != 0 && sum[AW-1]) r = '0;
    fin = r[T-1:0];
    if (SAT != 0) begin
      if (r > maxv)      fin = maxv[T-1:0];
      else if (r < minv) fin = minv[T-1:0];
    end
  end
endmodule

module layer_mvm_par #(
  parameter int M    = 8,
  parameter int N    = 4,
  parameter int T    = 16,
  parameter int P    = 2,
  parameter int RELU = 1,
  parameter int SAT  = 1,
  localparam int G   = M / P,
  localparam int WAW = (G*N > 1) ? $clog2(G*N) : 1,
  localparam int BAW = (G > 1) ? $clog2(G) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [T-1:0]   data_in,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [T-1:0]   data_out,
  output logic [WAW-1:0] w_addr,
  input  logic [P*T-1:0] w_data,
  output logic [BAW-1:0] b_addr,
  input  logic [P*T-1:0] b_data,
  output logic           busy
);
  localparam int AW = 2*T + $clog2(N) + 1;
  localparam int XW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(N + 2);
  localparam int OW = (M > 1) ? $clog2(M) : 1;

  typedef enum logic {FILL, FULL} in_state_t;
  typedef enum logic [1:0] {IDLE, MAC, OUT} cmp_state_t;

  in_state_t           in_st;
  cmp_state_t          cst;
  logic [XW-1:0]       cnt, xi;
  logic [T-1:0]        xbuf [N];
  logic [T-1:0]        xcur;
  logic [CW-1:0]       cyc;
  logic [OW-1:0]       oidx;
  logic [M-1:0][T-1:0] y;
  logic [P-1:0][T-1:0] fin;
  logic                grp_end, mac_last, ld_bias, ld_prod, acc_en;

  assign grp_end  = (cst == MAC) && (cyc == CW'(N + 1));
  assign mac_last = grp_end && (b_addr == BAW'(G - 1));
  assign ld_bias  = (cst == MAC) && (cyc == CW'(1));
  assign ld_prod  = (cst == MAC) && (cyc != '0) && (int'(cyc) <= N);
  assign acc_en   = (cst == MAC) && (int'(cyc) >= 2);
  assign xi       = XW'(cyc - CW'(1));
  assign xcur     = xbuf[xi];

  assign s_ready  = (in_st == FILL) && !reset;
  assign m_valid  = (cst == OUT);
  assign data_out = y[oidx];
  assign busy     = (cnt != '0) || (in_st == FULL) || (cst != IDLE);

  // x buffer is released as soon as the last group's MAC finishes, so the next
  // vector loads while results drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_st <= FILL;
      cnt   <= '0;
    end else if (in_st == FILL) begin
      if (s_valid) begin
        xbuf[cnt] <= data_in;
        if (cnt == XW'(N - 1)) begin
          in_st <= FULL;
          cnt   <= '0;
        end else begin
          cnt <= cnt + XW'(1);
        end
      end
    end else if (mac_last) begin
      in_st <= FILL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cst    <= IDLE;
      cyc    <= '0;
      w_addr <= '0;
      b_addr <= '0;
      oidx   <= '0;
      y      <= '0;
    end else begin
      case (cst)
        IDLE: if (in_st == FULL) begin
          cst    <= MAC;
          cyc    <= '0;
          w_addr <= '0;
          b_addr <= '0;
        end
        MAC: begin
          if (grp_end) begin
            cyc <= '0;
            for (int i = 0; i < M; i++)
              if (int'(b_addr) == i / P) y[i] <= fin[i % P];
            if (b_addr == BAW'(G - 1)) begin
              cst    <= OUT;
              oidx   <= '0;
              w_addr <= '0;
              b_addr <= '0;
            end else begin
              w_addr <= w_addr + WAW'(1);
              b_addr <= b_addr + BAW'(1);
            end
          end else begin
            cyc <= cyc + CW'(1);
            // Address advances for columns 1..N-1; it then holds until the next group.
            if (int'(cyc) < N - 1) w_addr <= w_addr + WAW'(1);
          end
        end
        OUT: if (m_ready) begin
          if (oidx == OW'(M - 1)) begin
            oidx <= '0;
            cst  <= (in_st == FULL) ? MAC : IDLE;
          end else begin
            oidx <= oidx + OW'(1);
          end
        end
        default: cst <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < P; k++) begin : g_lane
    layer_mvm_lane #(.T(T), .AW(AW), .RELU(RELU), .SAT(SAT)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .ld_bias (ld_bias),
      .ld_prod (ld_prod),
      .acc_en  (acc_en),
      .b       (b_data[k*T +: T]),
      .w       (w_data[k*T +: T]),
      .x       (xcur),
      .fin     (fin[k])
    );
  end
endmodule
